shift_unit: RTL
===============

Name: shift_unit

Overview:
- Parametrised multi-cycle shift/rotate execution unit for the Zero VM FPGA datapath.
- Generalises the single-bit-width shiftLeft instruction to five modes: logical left, logical right, arithmetic right, rotate left and rotate right.
- Shifts by up to STEP bits per cycle, so area can be traded against latency.
- The instruction sequencer hands it one operation at a time through a valid/ready handshake and collects the result through a second valid/ready handshake.

Parameters:
- WIDTH, 12: operand and result width in bits; matches MemoryElementWidth.
- STEP, 4: maximum bits shifted per cycle, 1..WIDTH.
- AW, 12: width of the shift-amount input.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  unit can accept an operation.
- op  input  3  mode: 0 SHL, 1 SHR, 2 SAR, 3 ROL, 4 ROR; 5..7 illegal.
- operand  input  WIDTH  value to shift.
- amount  input  AW  unsigned shift count.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  shifted value.
- overflow  output  1  SHL only: a 1 bit was shifted out.
- illegal  output  1  op was 5..7.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; in_ready = 1.
  - out_valid = 0, result = 0, overflow = 0, illegal = 0.
  - Internal remaining count and registers are cleared.
- Reset mid-operation aborts the operation; no result is ever presented for it.
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE, in_ready = 1:
  - On in_valid: latch op and operand, compute the effective amount, clear the sticky overflow.
  - If eff = 0 or op is illegal, go to DONE; otherwise go to SHIFT.
- Effective amount (eff):
  - SHL/SHR/SAR: eff = min(amount, WIDTH).
  - ROL/ROR: eff = amount mod WIDTH.
- SHIFT, in_ready = 0:
  - Each cycle, shift the working register by k = min(STEP, remaining) and set remaining -= k.
  - SHL shifts in zeros. SHR shifts in zeros. SAR shifts in copies of the original MSB. ROL/ROR wrap the bits.
  - SHL: OR any nonzero bit leaving the top into sticky overflow.
  - When remaining reaches 0, go to DONE.
- DONE:
  - out_valid = 1; result, overflow and illegal are held stable.
  - When out_ready = 1, go to IDLE on that edge.
  - in_ready stays 0 until IDLE is re-entered; no accept occurs in the same cycle as the result handshake.
- Illegal op:
  - result = operand unchanged; illegal = 1; overflow = 0; latency as for eff = 0.
- Latency: out_valid rises 1 + ceil(eff/STEP) rising edges after the accept edge.
- Saturation cases:
  - amount >= WIDTH for SHL/SHR gives result 0.
  - For SAR it gives all bits equal to the operand MSB.
  - Saturated SHL sets overflow iff operand != 0.
- Amount wrap: amount is unsigned; no negative shifts.
- Width rules:
  - All arithmetic is confined to WIDTH bits.
  - The remaining count is clog2(WIDTH+1) bits wide.
- Input stability: inputs are sampled only on the accept edge; later changes to the inputs are ignored.

Decomposition:
- Package zero_shift_pkg:
  - Enum shift_op_t {SHL, SHR, SAR, ROL, ROR}.
  - State enum {IDLE, SHIFT, DONE}.
  - A function computing eff from op, amount and WIDTH.
- Sub-module shift_step:
  - Purely combinational single-step shifter: inputs value, k (0..STEP), op, fill bit; outputs shifted value and lost-bits-nonzero.
  - Instantiated once inside shift_unit.

Test Plan:
- SHL, operand 1, amount 1, WIDTH 12, STEP 4 -> result 2 after 2 edges, overflow 0, illegal 0.
- SAR, operand 0x800, amount 3 -> result 0xF00. SAR, operand 0x800, amount 40 -> result 0xFFF after 4 edges (eff = 12, three SHIFT cycles).
- ROL, operand 0x801, amount 13 (eff 1) -> result 0x003. ROR, operand 0x001, amount 12 (eff 0) -> result 0x001 after 1 edge.
- SHL, operand 0x0F0, amount 12 -> result 0, overflow 1. SHL, operand 0, amount 12 -> result 0, overflow 0.
- Backpressure: hold out_ready = 0 for 5 cycles after a SHR of 0xABC by 4 -> result stays 0x0AB and in_ready stays 0; raise out_ready -> IDLE the next cycle.
- Edge cases:
  - op = 6 -> illegal 1 and result = operand.
  - Assert reset during SHIFT, asynchronous to the clock -> out_valid 0 and in_ready 1 immediately; the next operation completes correctly.

Source files
------------

// File: rtl/shift_unit_pkg.sv
// zero_shift_pkg: shared types and effective-amount helper for the shift/rotate unit.
package zero_shift_pkg;
   typedef enum logic [2:0] {SHL, SHR, SAR, ROL, ROR} shift_op_t;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   // Shifts saturate at the operand width; rotates wrap modulo the width.
   function automatic int unsigned effAmount(logic [2:0] op, int unsigned amount, int unsigned width);
      if (op == ROL || op == ROR) return amount % width;
      return amount < width ? amount : width;
   endfunction
endpackage

// File: rtl/shift_unit_if.sv
// shift_unit_if: request/result handshake bundle between the sequencer and the shift unit.
interface shift_unit_if #(parameter int WIDTH = 12, parameter int AW = 12);
   logic in_valid;
   logic in_ready;
   logic [2:0] op;
   logic [WIDTH-1:0] operand;
   logic [AW-1:0] amount;
   logic out_valid;
   logic out_ready;
   logic [WIDTH-1:0] result;
   logic overflow;
   logic illegal;
   modport master (
      output in_valid, op, operand, amount, out_ready,
      input in_ready, out_valid, result, overflow, illegal
   );
   modport slave (
      input in_valid, op, operand, amount, out_ready,
      output in_ready, out_valid, result, overflow, illegal
   );
endinterface

// File: rtl/shift_unit_step.sv
// shift_step: combinational shifter moving a value by 0..STEP bits in one of the five modes.
module shift_step
   import zero_shift_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int STEP = 4
) (
   input logic [WIDTH-1:0] value,
   input logic [$clog2(STEP+1)-1:0] k,
   input shift_op_t op,
   input logic fill,
   output logic [WIDTH-1:0] shifted,
   output logic lost
);
   logic [2*WIDTH-1:0] sarWide, rolWide, rorWide;
   always_comb begin
      sarWide = {{WIDTH{fill}}, value} >> k;
      rolWide = {value, value} << k;
      rorWide = {value, value} >> k;
      // A shift by WIDTH yields zero, so k = 0 reports nothing lost.
      lost = (op == SHL) && (|(value >> (WIDTH - int'(k))));
      shifted = op == SHL ? value << k :
                op == SHR ? value >> k :
                op == SAR ? sarWide[WIDTH-1:0] :
                op == ROL ? rolWide[2*WIDTH-1:WIDTH] :
                op == ROR ? rorWide[WIDTH-1:0] : value;
   end
endmodule

// File: rtl/shift_unit.sv
// shift_unit: multi-cycle shift/rotate unit shifting up to STEP bits per cycle behind valid/ready handshakes.
module shift_unit
   import zero_shift_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int STEP = 4,
   parameter int AW = 12
) (
   input logic clock,
   input logic reset,
   shift_unit_if.slave bus
);
   localparam int RW = $clog2(WIDTH + 1);
   localparam int KW = $clog2(STEP + 1);
   state_t state, stateNext;
   shift_op_t opReg;
   logic [WIDTH-1:0] work, stepOut;
   logic [RW-1:0] remaining, effIn, stepCount;
   logic overflowReg, illegalReg, fillBit, lost, illegalIn, accept;
   assign illegalIn = bus.op > 3'd4;
   assign effIn = RW'(effAmount(bus.op, 32'(bus.amount), WIDTH));
   assign stepCount = remaining < RW'(STEP) ? remaining : RW'(STEP);
   assign accept = state == IDLE && bus.in_valid;
   shift_step #(.WIDTH(WIDTH), .STEP(STEP)) step (
      .value(work),
      .k(KW'(stepCount)),
      .op(opReg),
      .fill(fillBit),
      .shifted(stepOut),
      .lost(lost)
   );
   always_comb begin
      stateNext = state;
      if (state == IDLE) stateNext = bus.in_valid ? ((effIn == '0 || illegalIn) ? DONE : SHIFT) : IDLE;
      else if (state == SHIFT) stateNext = remaining <= RW'(STEP) ? DONE : SHIFT;
      else stateNext = bus.out_ready ? IDLE : DONE;
   end
   // Illegal ops skip SHIFT with zero remaining, so the operand passes through untouched.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         opReg <= SHL;
         work <= '0;
         remaining <= '0;
         overflowReg <= 1'b0;
         illegalReg <= 1'b0;
         fillBit <= 1'b0;
      end else begin
         state <= stateNext;
         if (accept) begin
            opReg <= shift_op_t'(bus.op);
            work <= bus.operand;
            remaining <= illegalIn ? '0 : effIn;
            overflowReg <= 1'b0;
            illegalReg <= illegalIn;
            fillBit <= bus.operand[WIDTH-1];
         end else if (state == SHIFT) begin
            work <= stepOut;
            remaining <= remaining - stepCount;
            overflowReg <= overflowReg | lost;
         end
      end
   end
   assign bus.in_ready = state == IDLE;
   assign bus.out_valid = state == DONE;
   assign bus.result = work;
   assign bus.overflow = overflowReg;
   assign bus.illegal = illegalReg;
endmodule
